// File: rtl/if_id_buffer.sv
// Two-entry elastic buffer between fetch and decode with flush support.
// Optional statistics counters are built when IF_ID_BUFFER_STAT_EN is defined.
module if_id_buffer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 'h13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_add4,
  input  logic [XLEN-1:0] in_instr,
  output logic            in_ready,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_add4,
  output logic [XLEN-1:0] out_instr,
  output logic [31:0]     stall_cnt,
  output logic [15:0]     flush_cnt
);

  logic [XLEN-1:0] pc_mem    [2];
  logic [XLEN-1:0] add4_mem  [2];
  logic [XLEN-1:0] instr_mem [2];
  logic            wptr;
  logic            rptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  // in_ready looks only at count so decode stalls never reach the fetch path
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign out_pc      = out_valid ? pc_mem[rptr]    : '0;
  assign out_pc_add4 = out_valid ? add4_mem[rptr]  : '0;
  assign out_instr   = out_valid ? instr_mem[rptr] : NOP_INSTR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_mem[i]    <= '0;
        add4_mem[i]  <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        pc_mem[wptr]    <= in_pc;
        add4_mem[wptr]  <= in_pc_add4;
        instr_mem[wptr] <= in_instr;
        wptr            <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IF_ID_BUFFER_STAT_EN
  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer: streaming, fill, push/pop,
// flush and asynchronous reset, with optional statistics counters.
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_pc_add4;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_add4;
  logic [31:0] out_instr;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks   = 0;
  int failures = 0;

  if_id_buffer #(.XLEN(32), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_pc_add4  (in_pc_add4),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_pc_add4 (out_pc_add4),
    .out_instr   (out_instr),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [31:0] pc,
                                input logic rdy, input logic fl);
    in_valid   = valid;
    in_pc      = pc;
    in_pc_add4 = pc + 32'd4;
    in_instr   = 32'h0050_0093 + (pc << 18);
    out_ready  = rdy;
    flush      = fl;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h0050_0093 + (pc << 18);
  endfunction

  // Expected counter values depend on whether the statistics option is built
  function automatic logic [31:0] stat(input int n);
`ifdef IF_ID_BUFFER_STAT_EN
    return 32'(n);
`else
    return (n == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  initial begin
    rst = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("reset_out_pc", out_pc, 32'd0);
    check_output("reset_out_instr", out_instr, NOP);
    check_output("reset_stall_cnt", stall_cnt, 32'd0);
    check_output("reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Streaming with decode always ready
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'(i * 4), 1'b1, 1'b0);
      cycle();
      check_output($sformatf("stream_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check_output($sformatf("stream_pc_%0d", i), out_pc, 32'(i * 4));
      check_output($sformatf("stream_instr_%0d", i), out_instr, instr_of(32'(i * 4)));
      check_output($sformatf("stream_in_ready_%0d", i), {31'd0, in_ready}, 32'd1);
    end
    check_output("stream_instr_first", instr_of(32'h0), 32'h0050_0093);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    cycle();
    check_output("stream_drain_valid", {31'd0, out_valid}, 32'd0);
    check_output("stream_drain_instr", out_instr, NOP);

    // Fill to two entries with decode stalled
    apply_stimulus(1'b1, 32'h10, 1'b0, 1'b0);
    cycle();
    check_output("fill1_pc", out_pc, 32'h10);
    check_output("fill1_in_ready", {31'd0, in_ready}, 32'd1);
    apply_stimulus(1'b1, 32'h14, 1'b0, 1'b0);
    cycle();
    check_output("fill2_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("fill2_pc", out_pc, 32'h10);
    apply_stimulus(1'b1, 32'h18, 1'b0, 1'b0);
    cycle();
    check_output("fill3_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("fill3_pc", out_pc, 32'h10);
    check_output("fill3_add4", out_pc_add4, 32'h14);
    apply_stimulus(1'b1, 32'h18, 1'b1, 1'b0);
    cycle();
    check_output("drain1_pc", out_pc, 32'h14);
    check_output("drain1_in_ready", {31'd0, in_ready}, 32'd1);
    cycle();
    check_output("drain2_pc", out_pc, 32'h18);
    check_output("drain2_valid", {31'd0, out_valid}, 32'd1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    cycle();
    check_output("drain3_valid", {31'd0, out_valid}, 32'd0);
    check_output("fill_stall_cnt", stall_cnt, stat(2));

    // Simultaneous push and pop at one entry
    apply_stimulus(1'b1, 32'h20, 1'b0, 1'b0);
    cycle();
    check_output("pp_head", out_pc, 32'h20);
    apply_stimulus(1'b1, 32'h24, 1'b1, 1'b0);
    cycle();
    check_output("pp_pc", out_pc, 32'h24);
    check_output("pp_valid", {31'd0, out_valid}, 32'd1);
    check_output("pp_in_ready", {31'd0, in_ready}, 32'd1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    cycle();
    check_output("pp_empty", {31'd0, out_valid}, 32'd0);

    // Flush with a full buffer plus same-cycle input and consume
    apply_stimulus(1'b1, 32'h30, 1'b0, 1'b0);
    cycle();
    apply_stimulus(1'b1, 32'h34, 1'b0, 1'b0);
    cycle();
    check_output("preflush_in_ready", {31'd0, in_ready}, 32'd0);
    apply_stimulus(1'b1, 32'h40, 1'b1, 1'b1);
    cycle();
    check_output("flush_valid", {31'd0, out_valid}, 32'd0);
    check_output("flush_instr", out_instr, NOP);
    check_output("flush_pc", out_pc, 32'd0);
    check_output("flush_in_ready", {31'd0, in_ready}, 32'd1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    cycle();
    check_output("postflush_valid", {31'd0, out_valid}, 32'd0);
    check_output("flush_flush_cnt", {16'd0, flush_cnt}, stat(1));
    check_output("flush_stall_cnt", stall_cnt, stat(3));

    // Asynchronous reset between edges with two entries held
    apply_stimulus(1'b1, 32'h50, 1'b0, 1'b0);
    cycle();
    apply_stimulus(1'b1, 32'h54, 1'b0, 1'b0);
    cycle();
    check_output("prereset_pc", out_pc, 32'h50);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_output("areset_valid", {31'd0, out_valid}, 32'd0);
    check_output("areset_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("areset_pc", out_pc, 32'd0);
    check_output("areset_add4", out_pc_add4, 32'd0);
    check_output("areset_instr", out_instr, NOP);
    check_output("areset_stall_cnt", stall_cnt, 32'd0);
    check_output("areset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Three blocked fetch cycles after refilling
    apply_stimulus(1'b1, 32'h60, 1'b0, 1'b0);
    cycle();
    apply_stimulus(1'b1, 32'h64, 1'b0, 1'b0);
    cycle();
    apply_stimulus(1'b1, 32'h68, 1'b0, 1'b0);
    repeat (3) cycle();
    check_output("blocked_stall_cnt", stall_cnt, stat(3));
    check_output("blocked_pc", out_pc, 32'h60);
    check_output("blocked_in_ready", {31'd0, in_ready}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Two-entry elastic pipeline buffer between the fetch stage and the decode stage. It captures the fetch stage's PC, PC+4 and instruction word. It presents them to decode through a valid/ready handshake. It decouples a decode stall from the fetch timing path and drops in-flight instructions on a branch/jump flush. Fetch uses `in_ready` to hold its PC register; decode consumes `out_*`.

## Interface
Parameters:
- `XLEN`, 32: width of the PC, PC+4 and instruction fields.
- `NOP_INSTR`, 32'h0000_0013: instruction presented when the buffer is empty (`addi x0,x0,0`).

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  input  1  fetch presents a valid instruction.
- `in_pc`  input  XLEN  PC of the fetched instruction.
- `in_pc_add4`  input  XLEN  PC+4 of the fetched instruction.
- `in_instr`  input  XLEN  fetched instruction word.
- `in_ready`  output  1  buffer can accept this cycle.
- `flush`  input  1  discard all stored and incoming entries.
- `out_valid`  output  1  head entry valid.
- `out_ready`  input  1  decode accepts the head this cycle.
- `out_pc`  output  XLEN  head PC.
- `out_pc_add4`  output  XLEN  head PC+4.
- `out_instr`  output  XLEN  head instruction.
- `stall_cnt`  output  32  fetch-stall cycle counter (see Configuration).
- `flush_cnt`  output  16  flush event counter (see Configuration).

## Operation
- Storage: 2 entries of {pc, pc_add4, instr}, 1-bit write pointer `wptr`, 1-bit read pointer `rptr`, 2-bit `count` (0..2).
- Pointers toggle on use. Wrap-around is implicit in the 1-bit width.
- `push = in_valid & in_ready & ~flush`; `pop = out_valid & out_ready & ~flush`.
- `in_ready = (count != 2)`. It depends on `count` only, never on `out_ready`. When full, no push occurs even if a pop happens in the same cycle.
- `out_valid = (count != 0)`.
- `out_pc`/`out_pc_add4`/`out_instr` = entry[`rptr`] when `count != 0`. When empty they are 0 / 0 / `NOP_INSTR`.
- count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, with both pointers advancing.
- `flush` has priority over everything:
  - next state is `count=0`, `wptr=0`, `rptr=0`.
  - any same-cycle input is dropped.
  - any same-cycle `out_ready` is ignored; the head is not considered consumed.
- Entry contents are not cleared by flush or pop. Only reset clears them.
- Handshake rules:
  - Fetch holds `in_*` stable while `in_valid & ~in_ready`.
  - Once `out_valid` is high, the buffer holds `out_*` stable until pop or flush.

## Timing
- Reset (`rst`=0, asynchronous) takes effect immediately:
  - `count=0`, pointers 0, all entries 0.
  - `out_valid=0`, `in_ready=1`, `out_pc=0`, `out_pc_add4=0`, `out_instr=NOP_INSTR`.
  - `stall_cnt=0`, `flush_cnt=0`.
- Release of reset is synchronous to `clk`. The first push is possible at the first rising edge after release.
- Latency: an entry pushed at edge N is visible on `out_*` with `out_valid=1` after edge N. That is 1-cycle latency with no combinational input→output path.
- Throughput: 1 entry/cycle sustained when `out_ready` is held high.
- `in_ready` falls the cycle after the second unpopped push. It rises the cycle after a pop from full.
- Reset mid-operation loses all entries. There is no partial state.

## Configuration
- Macro `IF_ID_BUFFER_STAT_EN`.
- Defined:
  - `stall_cnt` increments on each cycle with `in_valid & ~in_ready`.
  - `flush_cnt` increments on each cycle with `flush=1`.
  - Both saturate at all-ones and are cleared only by reset.
- Undefined: no counter logic is built, and `stall_cnt` and `flush_cnt` are tied to 0.

## Test plan
- Reset then stream: `out_ready=1`, push pc 0x0,0x4,0x8 with instr 0x00500093,… on consecutive edges → `out_valid` high from cycle 1, `out_pc` 0x0,0x4,0x8 one cycle after each push, `in_ready` stays 1.
- Fill: `out_ready=0`, push 0x10 then 0x14 → `in_ready=0` after the second edge, `out_pc` held at 0x10; a third `in_valid` (0x18) is not accepted; raise `out_ready` → 0x10, 0x14, then 0x18 delivered in order.
- Simultaneous push/pop at count=1: head 0x20, push 0x24 while popping → count stays 1, `out_pc`=0x24 next cycle.
- Flush: count=2, assert `flush` with `in_valid=1` (pc 0x40) and `out_ready=1` → next cycle `out_valid=0`, `out_instr`=0x00000013, `in_ready=1`; 0x40 never appears.
- Async reset mid-operation: drop `rst` between edges with count=2 → outputs go to their reset values without a clock edge; with `IF_ID_BUFFER_STAT_EN`, `stall_cnt` is 0 after reset and counts 3 after three blocked `in_valid` cycles.
